// File: rtl/psg_pkg.sv
// Shared constants, default widths and FSM state encoding for the PSG write scheduler.
// The SILENCE state exists only when PSG_SCHED_SILENCE_EN is defined.
package psg_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_WE_CYCLES  = 1;
  localparam int DEF_GAP_CYCLES = 32;
  localparam int DEF_WAIT_BITS  = 8;

  // Command word: this bit selects wait (1) versus register write (0).
  localparam int CMD_WAIT_BIT = DEF_WAIT_BITS;

`ifdef PSG_SCHED_SILENCE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_WAIT,
    ST_SILENCE
  } psg_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_WAIT
  } psg_state_e;
`endif

  // Attenuator-off bytes for tone channels 0..2 and the noise channel.
  localparam logic [7:0] SILENCE_ATTN [0:3] = '{8'h9F, 8'hBF, 8'hDF, 8'hFF};

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO with push/pop/clear, registered level and combinational head read.
module psg_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Clear wins over a simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/psg_write_scheduler.sv
// Paces buffered host commands onto the PSG write port (byte + active-low strobe) and runs tick waits.
// Define PSG_SCHED_SILENCE_EN to mute all four attenuators after every flush.
module psg_write_scheduler
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WE_CYCLES  = DEF_WE_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int WAIT_BITS  = DEF_WAIT_BITS,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WAIT_BITS:0] cmd_data,
  input  logic               tick,
  input  logic               flush,
  output logic [7:0]         psg_data,
  output logic               psg_we_n,
  output logic               busy,
  output logic [LW-1:0]      fifo_level
);

  localparam int PACE_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
  localparam int PACE_W   = $clog2(PACE_MAX + 1);
  localparam int CNT_W    = (PACE_W > WAIT_BITS) ? PACE_W : WAIT_BITS;

  psg_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [7:0]         psg_data_reg, psg_data_next;
  logic               we_n_reg, we_n_next;
  logic               flush_pending_reg, flush_pending_next;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WAIT_BITS:0] fifo_head;
`ifdef PSG_SCHED_SILENCE_EN
  logic [1:0]         sil_idx_reg, sil_idx_next;
  logic               sil_active_reg, sil_active_next;
`endif

  psg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WAIT_BITS + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (cmd_valid && cmd_ready),
    .pop     (fifo_pop),
    .wr_data (cmd_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign cmd_ready = !fifo_full && !flush_pending_reg;
  assign busy      = (state_reg != ST_IDLE) || (fifo_level != '0);
  assign psg_data  = psg_data_reg;
  assign psg_we_n  = we_n_reg;

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    psg_data_next      = psg_data_reg;
    fifo_pop           = 1'b0;
    flush_pending_next = flush_pending_reg;
`ifdef PSG_SCHED_SILENCE_EN
    sil_idx_next       = sil_idx_reg;
    sil_active_next    = sil_active_reg;
`endif
    if (flush) begin
      flush_pending_next = 1'b1;
    end else if (state_reg == ST_IDLE) begin
      flush_pending_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
`ifdef PSG_SCHED_SILENCE_EN
        if (flush) begin
          state_next   = ST_SILENCE;
          sil_idx_next = 2'd0;
        end
`endif
        if (!flush && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_head[WAIT_BITS]) begin
            state_next = ST_WAIT;
            cnt_next   = CNT_W'(fifo_head[WAIT_BITS-1:0]);
          end else begin
            state_next    = ST_WRITE;
            psg_data_next = fifo_head[7:0];
            cnt_next      = CNT_W'(WE_CYCLES - 1);
          end
        end
      end

      ST_WRITE: begin
        if (cnt_reg == '0) begin
          state_next = ST_GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      // A flush never truncates the strobe; it takes effect at the end of the gap.
      ST_GAP: begin
        if (cnt_reg == '0) begin
`ifdef PSG_SCHED_SILENCE_EN
          if (sil_active_reg) begin
            if (sil_idx_reg == 2'd3) begin
              state_next      = ST_IDLE;
              sil_active_next = 1'b0;
            end else begin
              state_next   = ST_SILENCE;
              sil_idx_next = sil_idx_reg + 2'd1;
            end
          end else if (flush || flush_pending_reg) begin
            state_next   = ST_SILENCE;
            sil_idx_next = 2'd0;
          end else begin
            state_next = ST_IDLE;
          end
`else
          state_next = ST_IDLE;
`endif
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (flush) begin
`ifdef PSG_SCHED_SILENCE_EN
          state_next   = ST_SILENCE;
          sil_idx_next = 2'd0;
`else
          state_next = ST_IDLE;
`endif
        end else if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

`ifdef PSG_SCHED_SILENCE_EN
      ST_SILENCE: begin
        state_next      = ST_WRITE;
        psg_data_next   = SILENCE_ATTN[sil_idx_reg];
        cnt_next        = CNT_W'(WE_CYCLES - 1);
        sil_active_next = 1'b1;
      end
`endif

      default: state_next = ST_IDLE;
    endcase

    we_n_next = (state_next != ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      psg_data_reg      <= 8'h00;
      we_n_reg          <= 1'b1;
      flush_pending_reg <= 1'b0;
`ifdef PSG_SCHED_SILENCE_EN
      sil_idx_reg       <= 2'd0;
      sil_active_reg    <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      psg_data_reg      <= psg_data_next;
      we_n_reg          <= we_n_next;
      flush_pending_reg <= flush_pending_next;
`ifdef PSG_SCHED_SILENCE_EN
      sil_idx_reg       <= sil_idx_next;
      sil_active_reg    <= sil_active_next;
`endif
    end
  end

endmodule

// File: tb/tb_psg_write_scheduler.sv
// Directed bench for psg_write_scheduler: pacing, waits, full FIFO, flush and mid-operation reset.
// Expects PSG_SCHED_SILENCE_EN to be defined (or not) identically for bench and design.
module tb_psg_write_scheduler;
  import psg_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_data;
  logic       tick;
  logic       flush;
  logic [7:0] psg_data;
  logic       psg_we_n;
  logic       busy;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } wr_t;
  wr_t  wr_q[$];
  logic prev_we = 1'b1;

  psg_write_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .tick       (tick),
    .flush      (flush),
    .psg_data   (psg_data),
    .psg_we_n   (psg_we_n),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every falling strobe edge with its cycle number and byte.
  always @(negedge clk) begin
    if (prev_we === 1'b1 && psg_we_n === 1'b0) begin
      wr_q.push_back('{cyc: cyc, data: psg_data});
      $display("psg write: data=%02h cycle=%0d", psg_data, cyc);
    end
    prev_we <= psg_we_n;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [7:0] exp_data, input int exp_cyc);
    if (wr_q.size() > idx) begin
      chk({tag, "_data"}, wr_q[idx].data, exp_data);
      chk({tag, "_cycle"}, wr_q[idx].cyc, exp_cyc);
    end else begin
      chk({tag, "_missing"}, wr_q.size(), idx + 1);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; tick = 1'b0; flush = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset defaults
    chk("rst_we_n", psg_we_n, 1'b1);
    chk("rst_data", psg_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_ready", cmd_ready, 1'b1);

    // Single write: strobe low in cycle 2 only, busy clears after 32 gap cycles
    wr_q.delete();
    base = cyc;
    cmd_valid = 1'b1; cmd_data = 9'h08F;
    step();
    cmd_valid = 1'b0;
    chk("single_c1_level", fifo_level, 4'd1);
    chk("single_c1_we_n", psg_we_n, 1'b1);
    step();
    chk("single_c2_we_n", psg_we_n, 1'b0);
    chk("single_c2_data", psg_data, 8'h8F);
    chk("single_c2_level", fifo_level, 4'd0);
    step();
    chk("single_c3_we_n", psg_we_n, 1'b1);
    chk("single_c3_data", psg_data, 8'h8F);
    repeat (31) step();
    chk("single_c34_busy", busy, 1'b1);
    step();
    chk("single_c35_busy", busy, 1'b0);
    chk("single_count", wr_q.size(), 1);

    // Back-to-back writes 34 cycles apart, in order
    wr_q.delete();
    base = cyc;
    cmd_valid = 1'b1; cmd_data = 9'h081;
    step();
    cmd_data = 9'h03F;
    step();
    cmd_valid = 1'b0;
    wait_idle("b2b", 200);
    chk("b2b_count", wr_q.size(), 2);
    chk_wr("b2b_w0", 0, 8'h81, base + 2);
    chk_wr("b2b_w1", 1, 8'h3F, base + 36);

    // Wait 3 ticks (ticks every 10 cycles), then write 0x9F
    wr_q.delete();
    base = cyc;
    for (int k = 0; k < 40; k++) begin
      cmd_valid = (k < 2);
      cmd_data  = (k == 0) ? 9'h103 : 9'h09F;
      tick      = (k == 10 || k == 20 || k == 30);
      if (k == 30) chk("wait3_no_early_write", wr_q.size(), 0);
      step();
    end
    cmd_valid = 1'b0; tick = 1'b0;
    wait_idle("wait3", 200);
    chk_wr("wait3_w0", 0, 8'h9F, base + 33);

    // Wait 0 costs a single WAIT cycle
    wr_q.delete();
    base = cyc;
    cmd_valid = 1'b1; cmd_data = 9'h100;
    step();
    cmd_data = 9'h055;
    step();
    cmd_valid = 1'b0;
    wait_idle("wait0", 200);
    chk_wr("wait0_w0", 0, 8'h55, base + 4);

    // Full FIFO while stalled in wait 5; ninth push held until a pop
    wr_q.delete();
    base = cyc;
    for (int k = 0; k <= 22; k++) begin
      cmd_valid = (k <= 20);
      if (k == 0)      cmd_data = 9'h105;
      else if (k <= 8) cmd_data = {1'b0, 8'(8'hA0 + k - 1)};
      else             cmd_data = 9'h0A8;
      tick = (k >= 13 && k <= 17);
      if (k == 9)  begin chk("full_k9_level", fifo_level, 4'd8);  chk("full_k9_ready", cmd_ready, 1'b0);  end
      if (k == 12) begin chk("full_k12_level", fifo_level, 4'd8); chk("full_k12_ready", cmd_ready, 1'b0); end
      if (k == 19) begin chk("full_k19_level", fifo_level, 4'd8); chk("full_k19_ready", cmd_ready, 1'b0); end
      if (k == 20) begin chk("full_k20_level", fifo_level, 4'd7); chk("full_k20_ready", cmd_ready, 1'b1); end
      if (k == 21) chk("full_k21_level", fifo_level, 4'd8);
      step();
    end
    cmd_valid = 1'b0; tick = 1'b0;
    wait_idle("full", 400);
    chk("full_count", wr_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk_wr($sformatf("full_w%0d", i), i, 8'(8'hA0 + i), base + 20 + 34 * i);
    end

    // Flush during a WRITE pulse
    wr_q.delete();
    base = cyc;
    for (int k = 0; k <= 40; k++) begin
      cmd_valid = (k < 3);
      cmd_data  = {1'b0, 8'(8'h90 + k)};
      flush     = (k == 2);
      if (k == 2) begin chk("flush_k2_we_n", psg_we_n, 1'b0); chk("flush_k2_data", psg_data, 8'h90); end
      if (k == 3) begin
        chk("flush_k3_we_n", psg_we_n, 1'b1);
        chk("flush_k3_level", fifo_level, 4'd0);
        chk("flush_k3_ready", cmd_ready, 1'b0);
      end
      if (k == 20) begin chk("flush_k20_busy", busy, 1'b1); chk("flush_k20_ready", cmd_ready, 1'b0); end
`ifdef PSG_SCHED_SILENCE_EN
      if (k == 36) begin chk("sil_k36_we_n", psg_we_n, 1'b0); chk("sil_k36_data", psg_data, 8'h9F); end
`else
      if (k == 35) chk("flush_k35_busy", busy, 1'b0);
      if (k == 36) chk("flush_k36_ready", cmd_ready, 1'b1);
`endif
      step();
    end
    cmd_valid = 1'b0; flush = 1'b0;
`ifdef PSG_SCHED_SILENCE_EN
    chk("sil_mid_ready", cmd_ready, 1'b0);
    chk("sil_mid_busy", busy, 1'b1);
`endif
    wait_idle("flush", 300);
    chk_wr("flush_w0", 0, 8'h90, base + 2);
`ifdef PSG_SCHED_SILENCE_EN
    chk("sil_count", wr_q.size(), 5);
    chk_wr("sil_w0", 1, 8'h9F, base + 36);
    chk_wr("sil_w1", 2, 8'hBF, base + 70);
    chk_wr("sil_w2", 3, 8'hDF, base + 104);
    chk_wr("sil_w3", 4, 8'hFF, base + 138);
`else
    chk("flush_count", wr_q.size(), 1);
`endif

    // Mid-operation reset while in GAP with one command still queued
    wr_q.delete();
    cmd_valid = 1'b1; cmd_data = 9'h077;
    step();
    cmd_data = 9'h078;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("rstgap_k5_level", fifo_level, 4'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstgap_we_n", psg_we_n, 1'b1);
    chk("rstgap_level", fifo_level, 4'd0);
    chk("rstgap_busy", busy, 1'b0);
    chk("rstgap_data", psg_data, 8'h00);
    base = cyc;
    cmd_valid = 1'b1; cmd_data = 9'h08A;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstgap_new_we_n", psg_we_n, 1'b0);
    chk("rstgap_new_data", psg_data, 8'h8A);
    wait_idle("rstgap", 200);
    chk("rstgap_count", wr_q.size(), 2);
    chk_wr("rstgap_w1", 1, 8'h8A, base + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
